shk_fifo_bridge: RTL and testbench
==================================

// Module: shk_fifo_bridge
// PURPOSE
//  Buffering bridge between a shake-bus master (e.g. the shake simulator) and a downstream shake slave.
//  Slave port accepts valid pulses into a FIFO and acks each with a one-cycle ready echo.
//  Master port replays entries in order: one valid pulse per entry, then waits for the downstream ready.
//  Overflow, response mismatch and (optionally) timeout are reported on the error-info bus.
// PARAMETERS
//  WD_SHK_DATA    16    shake data width
//  WD_SHK_ADDR    16    shake address width
//  NB_FIFO_DEPTH  16    FIFO entries; power of two, >=2
//  NB_WAIT_MAX    1024  WAIT cycles before timeout (used only with SHK_FIFO_TIMEOUT_EN)
//  WD_ERR_INFO    4     error-info width; fixed at 4
// PORTS
//  i_sys_clk        in   1   system clock
//  i_sys_reset      in   1   asynchronous, active-high reset
//  s_shk_br_valid   in   1   upstream request pulse
//  s_shk_br_msync   in   1   upstream sync marker, stored with the entry
//  s_shk_br_mdata   in   WD_SHK_DATA  upstream data
//  s_shk_br_maddr   in   WD_SHK_ADDR  upstream address
//  s_shk_br_ready   out  1   one-cycle accept acknowledge
//  s_shk_br_ssync   out  1   echo of accepted msync
//  s_shk_br_sdata   out  WD_SHK_DATA  echo of accepted mdata
//  s_shk_br_saddr   out  WD_SHK_ADDR  echo of accepted maddr
//  m_shk_br_valid   out  1   downstream request pulse
//  m_shk_br_msync   out  1   head-entry sync marker
//  m_shk_br_mdata   out  WD_SHK_DATA  head-entry data
//  m_shk_br_maddr   out  WD_SHK_ADDR  head-entry address
//  m_shk_br_ready   in   1   downstream acknowledge pulse
//  m_shk_br_ssync   in   1   downstream sync echo (ignored)
//  m_shk_br_sdata   in   WD_SHK_DATA  downstream data echo (ignored)
//  m_shk_br_saddr   in   WD_SHK_ADDR  downstream address echo; compared with the head entry
//  m_err_br_info1   out  WD_ERR_INFO  [0] overflow (sticky), [1] timeout (sticky), [2] addr mismatch (sticky), [3] FIFO full (live)
// BEHAVIOUR
//  Reset (asynchronous): FIFO count and pointers 0, FSM IDLE, every output 0, sticky error bits cleared.
//  Reset is the only way to clear the sticky bits.
//  Write: s_valid=1 with count<DEPTH stores {msync,maddr,mdata} at the clock edge.
//   The following cycle, s_ready=1 for exactly one cycle, with ssync/saddr/sdata = the stored fields.
//   Otherwise s_ready=0; the echo outputs hold their last values.
//  Full: a request arriving while count==DEPTH is dropped (no ready) and sets err[0].
//   This holds even if a pop happens in the same cycle.
//  Pop and write in the same cycle: count unchanged, pointers wrap modulo DEPTH.
//  Master FSM:
//   IDLE:  count>0 -> ISSUE.
//   ISSUE: m_valid=1 for exactly one cycle, with msync/maddr/mdata = head entry -> WAIT; wait counter cleared.
//   WAIT:  m_ready=1 -> pop head, -> IDLE. If m_saddr != head maddr in that cycle, set err[2]; the entry is still popped.
//  m_ready is ignored in IDLE and ISSUE.
//  m_msync/maddr/mdata track the head entry at all times; they are 0 when the FIFO is empty.
//  Minimum latency: s_valid in cycle t -> m_valid in cycle t+2. Back-to-back master transfers take 3 cycles each.
//  err[3] = (count==DEPTH), combinational from registered state.
// CONFIGURATION
//  SHK_FIFO_TIMEOUT_EN defined:
//   The wait counter runs in WAIT. On reaching NB_WAIT_MAX-1 without ready: set err[1], return to ISSUE, re-send the same head.
//   The counter saturates; there is no pop on timeout.
//  SHK_FIFO_TIMEOUT_EN undefined:
//   No wait counter; WAIT holds until m_ready. err[1] is tied to 0.
// STRUCTURE
//  Package shk_pkg: localparams for err-bit indices (ERR_OVF=0, ERR_TMO=1, ERR_MIS=2, ERR_FULL=3) and FSM state encodings (IDLE/ISSUE/WAIT).
//  Package shk_pkg also holds the entry width function WD_SHK_DATA+WD_SHK_ADDR+1.
//  Sub-module shk_fifo_mem: synchronous-write, asynchronous-read storage array with wr/rd pointers and count.
//  Handshake logic and FSM live in shk_fifo_bridge.
// TESTING
//  1 Single write {addr=0x0010,data=0x0008,sync=0} at t -> s_ready at t+1 with echo 0x0010/0x0008; m_valid at t+2 with the same fields.
//  2 Downstream ready at t+4 -> pop, FSM IDLE at t+5; count returns to 0; m_maddr/mdata read 0.
//  3 Write 17 entries with no downstream ready, DEPTH=16 -> 16 readies, 17th dropped, err[0]=1, err[3]=1.
//   Then drain with ready pulses -> addresses come out in write order.
//  4 Ready returned with saddr=0x0011 for head maddr=0x0010 -> err[2]=1, entry popped, next entry issued.
//  5 (SHK_FIFO_TIMEOUT_EN, NB_WAIT_MAX=8) No ready -> err[1]=1 and m_valid re-pulses every 9 cycles with the same head.
//   Without the macro -> single pulse, FSM stays in WAIT.
//  6 Assert i_sys_reset between edges with 5 entries queued -> all outputs 0 immediately.
//   After release, no m_valid until a new write.

Source files
------------

// File: rtl/shk_pkg.sv
// Shared definitions for the shake FIFO bridge: error-bit indices, master FSM states, entry width.
package shk_pkg;

  localparam int ERR_OVF  = 0;
  localparam int ERR_TMO  = 1;
  localparam int ERR_MIS  = 2;
  localparam int ERR_FULL = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // A stored entry is {msync, maddr, mdata}.
  function automatic int entry_width(input int wd_data, input int wd_addr);
    return wd_data + wd_addr + 1;
  endfunction

endpackage

// File: rtl/shk_fifo_mem.sv
// Entry storage: registered write, combinational read of the head entry; a push and a pop in one cycle leave count unchanged.
module shk_fifo_mem #(
  parameter int WD_ENT   = 33,
  parameter int NB_DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [WD_ENT-1:0]         wr_data,
  input  logic                      rd_en,
  output logic [WD_ENT-1:0]         rd_data,
  output logic [$clog2(NB_DEPTH):0] count
);
  localparam int WD_PTR = $clog2(NB_DEPTH);
  localparam logic [WD_PTR-1:0] PTR_ONE = 1;
  localparam logic [WD_PTR:0]   CNT_ONE = 1;

  logic [WD_ENT-1:0] mem [NB_DEPTH];
  logic [WD_PTR-1:0] wr_ptr;
  logic [WD_PTR-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/shk_fifo_bridge.sv
// Shake bridge: s_valid at t gives m_valid at t+2, 3 cycles per master transfer; full FIFO drops requests (err[0]).
// SHK_FIFO_TIMEOUT_EN adds a WAIT timeout that flags err[1] and re-issues the head entry.
module shk_fifo_bridge
  import shk_pkg::*;
#(
  parameter int WD_SHK_DATA   = 16,
  parameter int WD_SHK_ADDR   = 16,
  parameter int NB_FIFO_DEPTH = 16,
  parameter int NB_WAIT_MAX   = 1024,
  parameter int WD_ERR_INFO   = 4
) (
  input  logic                   i_sys_clk,
  input  logic                   i_sys_reset,
  input  logic                   s_shk_br_valid,
  input  logic                   s_shk_br_msync,
  input  logic [WD_SHK_DATA-1:0] s_shk_br_mdata,
  input  logic [WD_SHK_ADDR-1:0] s_shk_br_maddr,
  output logic                   s_shk_br_ready,
  output logic                   s_shk_br_ssync,
  output logic [WD_SHK_DATA-1:0] s_shk_br_sdata,
  output logic [WD_SHK_ADDR-1:0] s_shk_br_saddr,
  output logic                   m_shk_br_valid,
  output logic                   m_shk_br_msync,
  output logic [WD_SHK_DATA-1:0] m_shk_br_mdata,
  output logic [WD_SHK_ADDR-1:0] m_shk_br_maddr,
  input  logic                   m_shk_br_ready,
  input  logic                   m_shk_br_ssync,
  input  logic [WD_SHK_DATA-1:0] m_shk_br_sdata,
  input  logic [WD_SHK_ADDR-1:0] m_shk_br_saddr,
  output logic [WD_ERR_INFO-1:0] m_err_br_info1
);
  localparam int WD_ENT = entry_width(WD_SHK_DATA, WD_SHK_ADDR);
  localparam int WD_CNT = $clog2(NB_FIFO_DEPTH) + 1;
  localparam logic [WD_CNT-1:0] CNT_FULL = WD_CNT'(NB_FIFO_DEPTH);

  state_t                 state;
  state_t                 state_nxt;
  logic [WD_ENT-1:0]      head;
  logic [WD_CNT-1:0]      count;
  logic                   head_sync;
  logic [WD_SHK_ADDR-1:0] head_addr;
  logic [WD_SHK_DATA-1:0] head_data;
  logic                   full;
  logic                   non_empty;
  logic                   wr_en;
  logic                   pop;
  logic                   tmo;
  logic                   err_ovf;
  logic                   err_tmo;
  logic                   err_mis;
  logic                   unused_in;

  assign unused_in = ^{m_shk_br_ssync, m_shk_br_sdata, 1'(NB_WAIT_MAX)};

  assign full      = (count == CNT_FULL);
  assign non_empty = (count != '0);
  assign wr_en     = s_shk_br_valid && !full;
  assign pop       = (state == WAIT) && m_shk_br_ready;
  assign {head_sync, head_addr, head_data} = head;

  shk_fifo_mem #(
    .WD_ENT   (WD_ENT),
    .NB_DEPTH (NB_FIFO_DEPTH)
  ) u_mem (
    .clk     (i_sys_clk),
    .rst     (i_sys_reset),
    .wr_en   (wr_en),
    .wr_data ({s_shk_br_msync, s_shk_br_maddr, s_shk_br_mdata}),
    .rd_en   (pop),
    .rd_data (head),
    .count   (count)
  );

`ifdef SHK_FIFO_TIMEOUT_EN
  localparam int WD_WCNT = $clog2(NB_WAIT_MAX);
  localparam logic [WD_WCNT-1:0] WCNT_MAX = WD_WCNT'(NB_WAIT_MAX - 1);
  localparam logic [WD_WCNT-1:0] WCNT_ONE = 1;
  logic [WD_WCNT-1:0] wait_cnt;

  always_ff @(posedge i_sys_clk or posedge i_sys_reset) begin
    if (i_sys_reset)                             wait_cnt <= '0;
    else if (state == ISSUE)                     wait_cnt <= '0;
    else if (state == WAIT && wait_cnt != WCNT_MAX) wait_cnt <= wait_cnt + WCNT_ONE;
  end

  // Ready on the last wait cycle still wins over the timeout.
  assign tmo = (state == WAIT) && !m_shk_br_ready && (wait_cnt == WCNT_MAX);

  always_ff @(posedge i_sys_clk or posedge i_sys_reset) begin
    if (i_sys_reset) err_tmo <= 1'b0;
    else if (tmo)    err_tmo <= 1'b1;
  end
`else
  assign tmo     = 1'b0;
  assign err_tmo = 1'b0;
`endif

  always_ff @(posedge i_sys_clk or posedge i_sys_reset) begin
    if (i_sys_reset) state <= IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (non_empty) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT: begin
        if (m_shk_br_ready) state_nxt = IDLE;
        else if (tmo)       state_nxt = ISSUE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    m_shk_br_valid = (state == ISSUE);
    m_shk_br_msync = non_empty ? head_sync : 1'b0;
    m_shk_br_maddr = non_empty ? head_addr : '0;
    m_shk_br_mdata = non_empty ? head_data : '0;
  end

  always_ff @(posedge i_sys_clk or posedge i_sys_reset) begin
    if (i_sys_reset) begin
      s_shk_br_ready <= 1'b0;
      s_shk_br_ssync <= 1'b0;
      s_shk_br_saddr <= '0;
      s_shk_br_sdata <= '0;
    end else begin
      s_shk_br_ready <= wr_en;
      if (wr_en) begin
        s_shk_br_ssync <= s_shk_br_msync;
        s_shk_br_saddr <= s_shk_br_maddr;
        s_shk_br_sdata <= s_shk_br_mdata;
      end
    end
  end

  // Overflow is judged on the pre-edge count, so a same-cycle pop does not rescue the request.
  always_ff @(posedge i_sys_clk or posedge i_sys_reset) begin
    if (i_sys_reset) begin
      err_ovf <= 1'b0;
      err_mis <= 1'b0;
    end else begin
      if (s_shk_br_valid && full)                  err_ovf <= 1'b1;
      if (pop && (m_shk_br_saddr != head_addr))    err_mis <= 1'b1;
    end
  end

  always_comb begin
    m_err_br_info1           = '0;
    m_err_br_info1[ERR_OVF]  = err_ovf;
    m_err_br_info1[ERR_TMO]  = err_tmo;
    m_err_br_info1[ERR_MIS]  = err_mis;
    m_err_br_info1[ERR_FULL] = full;
  end

endmodule

// File: tb/tb_shk_fifo_bridge.sv
// Directed and randomized checks of shk_fifo_bridge against a queue-level model of the bridge.
module tb_shk_fifo_bridge;
  localparam int DEPTH = 16;
  localparam int WMAX  = 8;

  typedef struct packed {
    logic        s;
    logic [15:0] a;
    logic [15:0] d;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid, s_msync, s_ready, s_ssync;
  logic [15:0] s_mdata, s_maddr, s_sdata, s_saddr;
  logic        m_valid, m_msync, m_ready, m_ssync;
  logic [15:0] m_mdata, m_maddr, m_sdata, m_saddr;
  logic [3:0]  err;

  int   n_pass  = 0;
  int   n_total = 0;
  ent_t q[$];
  ent_t last, hd;
  logic exp_rdy, outst, do_pop, e_ovf, e_mis, exp_mv;

  always #5 clk = ~clk;

  shk_fifo_bridge #(
    .WD_SHK_DATA(16), .WD_SHK_ADDR(16), .NB_FIFO_DEPTH(DEPTH), .NB_WAIT_MAX(WMAX), .WD_ERR_INFO(4)
  ) dut (
    .i_sys_clk(clk), .i_sys_reset(rst),
    .s_shk_br_valid(s_valid), .s_shk_br_msync(s_msync), .s_shk_br_mdata(s_mdata), .s_shk_br_maddr(s_maddr),
    .s_shk_br_ready(s_ready), .s_shk_br_ssync(s_ssync), .s_shk_br_sdata(s_sdata), .s_shk_br_saddr(s_saddr),
    .m_shk_br_valid(m_valid), .m_shk_br_msync(m_msync), .m_shk_br_mdata(m_mdata), .m_shk_br_maddr(m_maddr),
    .m_shk_br_ready(m_ready), .m_shk_br_ssync(m_ssync), .m_shk_br_sdata(m_sdata), .m_shk_br_saddr(m_saddr),
    .m_err_br_info1(err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_valid = 0; s_msync = 0; s_mdata = 0; s_maddr = 0;
    m_ready = 0; m_ssync = 0; m_sdata = 0; m_saddr = 0;
    q.delete();
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d, input logic s);
    s_valid = 1'b1; s_maddr = a; s_mdata = d; s_msync = s;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic wait_mv(input string tag, input int budget);
    int n = 0;
    while (!m_valid && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_mvalid_seen"}, m_valid, 1);
  endtask

  // Holds ready with the matching address until the head changes; ready is ignored outside WAIT.
  task automatic pop_head(input string tag);
    int n = 0;
    ent_t h;
    h = q[0];
    chk({tag, "_head"}, {m_msync, m_maddr, m_mdata}, h);
    m_ready = 1'b1;
    m_saddr = h.a;
    while (n < 40) begin
      tick();
      n++;
      if (m_maddr !== h.a) break;
    end
    m_ready = 1'b0;
    chk({tag, "_popped"}, m_maddr !== h.a, 1);
    void'(q.pop_front());
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    chk("rst_err", err, 0);
    chk("rst_srdy", s_ready, 0);
    chk("rst_mvalid", m_valid, 0);
    chk("rst_mfields", {m_msync, m_maddr, m_mdata}, 0);

    // Single write, latency and ISSUE-state ready being ignored
    wr(16'h0010, 16'h0008, 1'b0);
    chk("t1_srdy", s_ready, 1);
    chk("t1_echo", {s_ssync, s_saddr, s_sdata}, {1'b0, 16'h0010, 16'h0008});
    chk("t1_mvalid_early", m_valid, 0);
    tick();
    chk("t1_mvalid", m_valid, 1);
    chk("t1_mfields", {m_msync, m_maddr, m_mdata}, {1'b0, 16'h0010, 16'h0008});
    chk("t1_srdy_one", s_ready, 0);
    m_ready = 1'b1; m_saddr = 16'hBEEF;
    tick();
    m_ready = 1'b0;
    chk("t1_issue_rdy_ignored", m_maddr, 16'h0010);
    chk("t1_mvalid_one", m_valid, 0);
    chk("t1_err_clean", err, 0);
    tick();
    m_ready = 1'b1; m_saddr = 16'h0010;
    tick();
    m_ready = 1'b0;
    chk("t2_empty_fields", {m_msync, m_maddr, m_mdata}, 0);
    chk("t2_mvalid", m_valid, 0);
    chk("t2_err", err, 0);
    tick();
    chk("t2_idle", m_valid, 0);

    // Overflow: 17 writes, no pops
    do_reset();
    for (int i = 0; i < 17; i++) begin
      s_valid = 1'b1; s_maddr = 16'h0100 + 16'(i); s_mdata = 16'($urandom); s_msync = 1'($urandom);
      exp_rdy = (q.size() < DEPTH);
      last = '{s: s_msync, a: s_maddr, d: s_mdata};
      if (exp_rdy) q.push_back(last);
      tick();
      chk("t3_srdy", s_ready, exp_rdy);
    end
    s_valid = 1'b0;
    tick();
    chk("t3_ovf", err[0], 1);
    chk("t3_full", err[3], 1);
    chk("t3_srdy_dropped", s_ready, 0);
    while (q.size() > 0) pop_head("t3_drain");
    chk("t3_full_clear", err[3], 0);
    chk("t3_empty", m_maddr, 0);

    // Address mismatch on the returned ready
    wr(16'h0010, 16'h1111, 1'b0);
    wr(16'h0020, 16'h2222, 1'b1);
    wait_mv("t4a", 10);
    chk("t4_head0", m_maddr, 16'h0010);
    tick();
    m_ready = 1'b1; m_saddr = 16'h0011;
    tick();
    m_ready = 1'b0;
    chk("t4_mis", err[2], 1);
    chk("t4_popped", m_maddr, 16'h0020);
    wait_mv("t4b", 10);
    chk("t4_head1", {m_msync, m_maddr, m_mdata}, {1'b1, 16'h0020, 16'h2222});
    q.delete();
    q.push_back('{s: 1'b1, a: 16'h0020, d: 16'h2222});
    pop_head("t4_drain");

    // No ready: timeout re-issue or indefinite WAIT depending on build
    do_reset();
    chk("t5_tmo_clear", err[1], 0);
    wr(16'h0055, 16'h00AA, 1'b1);
    wait_mv("t5", 10);
    for (int k = 0; k < 30; k++) begin
`ifdef SHK_FIFO_TIMEOUT_EN
      exp_mv = (k % (WMAX + 1) == 0);
`else
      exp_mv = (k == 0);
`endif
      chk("t5_mvalid", m_valid, exp_mv);
      if (m_valid) chk("t5_same_head", m_maddr, 16'h0055);
      tick();
    end
`ifdef SHK_FIFO_TIMEOUT_EN
    chk("t5_tmo", err[1], 1);
`else
    chk("t5_tmo", err[1], 0);
`endif
    q.push_back('{s: 1'b1, a: 16'h0055, d: 16'h00AA});
    pop_head("t5_drain");

    // Asynchronous reset with entries queued
    do_reset();
    for (int i = 0; i < 5; i++) wr(16'h0200 + 16'(i), 16'(i), 1'b1);
    tick();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("t6_async_m", {m_valid, m_msync, m_maddr, m_mdata}, 0);
    chk("t6_async_s", {s_ready, s_ssync, s_saddr, s_sdata}, 0);
    chk("t6_async_err", err, 0);
    #2;
    rst = 1'b0;
    tick();
    for (int k = 0; k < 8; k++) begin
      chk("t6_quiet", m_valid, 0);
      tick();
    end
    wr(16'h0300, 16'h0001, 1'b0);
    tick();
    chk("t6_new_mvalid", m_valid, 1);
    chk("t6_new_head", m_maddr, 16'h0300);

    // Randomized traffic against the queue model
    do_reset();
    exp_rdy = 0; outst = 0; e_ovf = 0; e_mis = 0; last = '0;
    for (int c = 0; c < 500; c++) begin
      chk("rnd_srdy", s_ready, exp_rdy);
      if (exp_rdy) chk("rnd_echo", {s_ssync, s_saddr, s_sdata}, last);
      hd = (q.size() != 0) ? q[0] : '0;
      chk("rnd_head", {m_msync, m_maddr, m_mdata}, hd);
      chk("rnd_err", {err[3], err[2], err[0]}, {q.size() == DEPTH, e_mis, e_ovf});
      if (m_valid) begin
        chk("rnd_mvalid_nonempty", q.size() != 0, 1);
        outst = 1'b1;
      end
      s_valid = ($urandom_range(0, 9) < 3);
      s_maddr = 16'($urandom); s_mdata = 16'($urandom); s_msync = 1'($urandom);
      m_ready = !m_valid && ($urandom_range(0, 2) == 0);
      m_saddr = (q.size() != 0 && $urandom_range(0, 9) != 0) ? q[0].a : 16'($urandom);
      do_pop  = m_ready && outst;
      exp_rdy = s_valid && (q.size() < DEPTH);
      if (s_valid && !exp_rdy) e_ovf = 1'b1;
      if (do_pop) begin
        if (m_saddr !== q[0].a) e_mis = 1'b1;
        void'(q.pop_front());
        outst = 1'b0;
      end
      if (exp_rdy) begin
        last = '{s: s_msync, a: s_maddr, d: s_mdata};
        q.push_back(last);
      end
      tick();
    end
    s_valid = 1'b0;
    m_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
